// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer: command-driven DIGITS-wide cascaded BCD up/down counter.
// STOP / RUN_UP / RUN_DOWN / LOAD arrive over valid/ready; steps are paced by a prescaler.
// Build option: define BCD_AUTO_REVERSE_EN to bounce between the bounds (toggle direction,
// hold value) instead of the WRAP-selected wrap/halt behaviour.
module bcd_count_sequencer #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned WRAP     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [4*DIGITS-1:0] cmd_data,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                up_down,
    output logic                running,
    output logic                tc_pulse,
    output logic                cmd_err
);

    localparam int unsigned   BW       = 4 * DIGITS;
    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [BW-1:0] BCD_MAX  = {DIGITS{4'd9}};

    localparam logic [1:0] OP_STOP     = 2'b00;
    localparam logic [1:0] OP_RUN_UP   = 2'b01;
    localparam logic [1:0] OP_RUN_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bcd_q, bcd_d;
    logic [BW-1:0] preset_q, preset_d;
    logic          up_q, up_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ret_run_q, ret_run_d;
    logic          tc_q, tc_d;
    logic          err_q, err_d;
    logic          running_q, ready_q;

    logic [BW-1:0] inc_c, dec_c;
    logic          carry_c, borrow_c, data_ok_c;
    logic          accept_c, bad_load_c, take_c, at_bound_c;

    // Ripple BCD increment/decrement of the count and digit check of the LOAD preset
    always_comb begin
        inc_c     = bcd_q;
        dec_c     = bcd_q;
        carry_c   = 1'b1;
        borrow_c  = 1'b1;
        data_ok_c = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry_c) begin
                inc_c[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd9) ? 4'd0 : bcd_q[4*i +: 4] + 4'd1;
                carry_c         = (bcd_q[4*i +: 4] == 4'd9);
            end
            if (borrow_c) begin
                dec_c[4*i +: 4] = (bcd_q[4*i +: 4] == 4'd0) ? 4'd9 : bcd_q[4*i +: 4] - 4'd1;
                borrow_c        = (bcd_q[4*i +: 4] == 4'd0);
            end
            if (cmd_data[4*i +: 4] > 4'd9) begin
                data_ok_c = 1'b0;
            end
        end
    end

    assign at_bound_c = up_q ? (bcd_q == BCD_MAX) : (bcd_q == '0);
    assign accept_c   = cmd_valid && ready_q;
    assign bad_load_c = accept_c && (cmd_op == OP_LOAD) && !data_ok_c;
    assign take_c     = accept_c && !bad_load_c;

    // Next-state: accepted commands win over stepping; a rejected LOAD only flags cmd_err
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        preset_d  = preset_q;
        up_d      = up_q;
        presc_d   = presc_q;
        ret_run_d = ret_run_q;
        tc_d      = 1'b0;
        err_d     = bad_load_c;

        if (take_c) begin
            presc_d = '0;
            case (cmd_op)
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_RUN_UP, OP_RUN_DOWN: begin
                    up_d    = (cmd_op == OP_RUN_UP);
                    state_d = ST_RUN;
                end
                default: begin
                    preset_d  = cmd_data;
                    ret_run_d = (state_q == ST_RUN);
                    state_d   = ST_LOAD;
                end
            endcase
        end else begin
            case (state_q)
                ST_LOAD: begin
                    bcd_d   = preset_q;
                    state_d = ret_run_q ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (presc_q == PRE_LAST) begin
                        presc_d = '0;
                        if (at_bound_c) begin
                            tc_d = 1'b1;
`ifdef BCD_AUTO_REVERSE_EN
                            up_d = !up_q;
`else
                            if (WRAP != 0) begin
                                bcd_d = up_q ? '0 : BCD_MAX;
                            end else begin
                                state_d = ST_HALT;
                            end
`endif
                        end else begin
                            bcd_d = up_q ? inc_c : dec_c;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            preset_q  <= '0;
            up_q      <= 1'b1;
            presc_q   <= '0;
            ret_run_q <= 1'b0;
            tc_q      <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            preset_q  <= preset_d;
            up_q      <= up_d;
            presc_q   <= presc_d;
            ret_run_q <= ret_run_d;
            tc_q      <= tc_d;
            err_q     <= err_d;
            running_q <= (state_d == ST_RUN);
            ready_q   <= (state_d != ST_LOAD);
        end
    end

    assign cmd_ready = ready_q;
    assign bcd_out   = bcd_q;
    assign up_down   = up_q;
    assign running   = running_q;
    assign tc_pulse  = tc_q;
    assign cmd_err   = err_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// tb_bcd_count_sequencer: directed and randomized checks of bcd_count_sequencer.
// Two instances share stimulus: index 0 built with WRAP=1, index 1 with WRAP=0.
`timescale 1ns/1ps
module tb_bcd_count_sequencer;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int BW       = 4 * DIGITS;
    localparam int MAXV     = 10 ** DIGITS - 1;
    localparam int M_IDLE = 0, M_RUN = 1, M_LOAD = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [BW-1:0] cmd_data;
    logic          ready_o [2];
    logic [BW-1:0] bcd_o   [2];
    logic          up_o    [2];
    logic          run_o   [2];
    logic          tc_o    [2];
    logic          err_o   [2];

    int checks   = 0;
    int failures = 0;

    // Behavioural model: count held as an integer, mode as a small integer
    int m_val  [2];
    bit m_up   [2];
    int m_mode [2];
    int m_cnt  [2];
    int m_pre  [2];
    bit m_ret  [2];
    bit m_tc   [2];
    bit m_err  [2];

    bcd_count_sequencer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[0]),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .bcd_out(bcd_o[0]), .up_down(up_o[0]),
        .running(run_o[0]), .tc_pulse(tc_o[0]), .cmd_err(err_o[0])
    );

    bcd_count_sequencer #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .WRAP(0)) u_halt (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_o[1]),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .bcd_out(bcd_o[1]), .up_down(up_o[1]),
        .running(run_o[1]), .tc_pulse(tc_o[1]), .cmd_err(err_o[1])
    );

    always #5 clk = ~clk;

    function automatic bit bcd_ok(input logic [BW-1:0] d);
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(d[4*i +: 4]) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [BW-1:0] d);
        int acc = 0;
        for (int i = DIGITS - 1; i >= 0; i--) acc = acc * 10 + int'(d[4*i +: 4]);
        return acc;
    endfunction

    function automatic logic [BW-1:0] int2bcd(input int v);
        logic [BW-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_up[k] = 1'b1; m_mode[k] = M_IDLE; m_cnt[k] = 0;
            m_pre[k] = 0; m_ret[k] = 1'b0; m_tc[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    // One clock edge of the model for instance k, from the current command inputs
    task automatic model_edge(input int k);
        bit wrap = (k == 0);
        bit take;
        m_tc[k]  = 1'b0;
        m_err[k] = 1'b0;
        take = cmd_valid && (m_mode[k] != M_LOAD);
        if (take && cmd_op == 2'b11 && !bcd_ok(cmd_data)) begin
            m_err[k] = 1'b1;
            take = 1'b0;
        end
        if (take) begin
            m_cnt[k] = 0;
            case (cmd_op)
                2'b00: m_mode[k] = M_IDLE;
                2'b01: begin m_up[k] = 1'b1; m_mode[k] = M_RUN; end
                2'b10: begin m_up[k] = 1'b0; m_mode[k] = M_RUN; end
                default: begin
                    m_pre[k]  = bcd2int(cmd_data);
                    m_ret[k]  = (m_mode[k] == M_RUN);
                    m_mode[k] = M_LOAD;
                end
            endcase
        end else if (m_mode[k] == M_LOAD) begin
            m_val[k]  = m_pre[k];
            m_mode[k] = m_ret[k] ? M_RUN : M_IDLE;
        end else if (m_mode[k] == M_RUN) begin
            m_cnt[k]++;
            if (m_cnt[k] == PRESCALE) begin
                m_cnt[k] = 0;
                if ((m_up[k] && m_val[k] == MAXV) || (!m_up[k] && m_val[k] == 0)) begin
                    m_tc[k] = 1'b1;
`ifdef BCD_AUTO_REVERSE_EN
                    m_up[k] = !m_up[k];
`else
                    if (wrap) m_val[k] = m_up[k] ? 0 : MAXV;
                    else      m_mode[k] = M_HALT;
`endif
                end else begin
                    m_val[k] = m_up[k] ? m_val[k] + 1 : m_val[k] - 1;
                end
            end
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) model_edge(k);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] op, input logic [BW-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = BW'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        ticks(3);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== '0 || up_o[k] !== 1'b1 || run_o[k] !== 1'b0 ||
                tc_o[k] !== 1'b0 || err_o[k] !== 1'b0 || ready_o[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset inst%0d bcd=%h up=%b run=%b tc=%b err=%b rdy=%b exp 00/1/0/0/0/1",
                         k, bcd_o[k], up_o[k], run_o[k], tc_o[k], err_o[k], ready_o[k]);
            end
        end
    endtask

    task automatic test_count_up();
        do_reset();
        send(2'b01, '0);
        ticks(3);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== 8'h00 || run_o[k] !== 1'b1 || ready_o[k] !== 1'b1) begin
                failures++;
                $display("FAIL up_pre_step inst%0d bcd=%h run=%b rdy=%b exp 00/1/1", k, bcd_o[k], run_o[k], ready_o[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== 8'h01) begin
                failures++;
                $display("FAIL up_first_step inst%0d bcd=%h exp 01", k, bcd_o[k]);
            end
        end
        ticks(4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== 8'h02 || up_o[k] !== 1'b1) begin
                failures++;
                $display("FAIL up_second_step inst%0d bcd=%h up=%b exp 02/1", k, bcd_o[k], up_o[k]);
            end
        end
    endtask

`ifndef BCD_AUTO_REVERSE_EN
    task automatic test_wrap_halt();
        do_reset();
        send(2'b11, 8'h98);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ready_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL load_not_ready inst%0d rdy=%b exp 0", k, ready_o[k]);
            end
        end
        tick();
        send(2'b01, '0);
        ticks(4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== 8'h99 || tc_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL wrap_99 inst%0d bcd=%h tc=%b exp 99/0", k, bcd_o[k], tc_o[k]);
            end
        end
        ticks(4);
        checks++;
        if (bcd_o[0] !== 8'h00 || tc_o[0] !== 1'b1 || run_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_to_00 bcd=%h tc=%b run=%b exp 00/1/1", bcd_o[0], tc_o[0], run_o[0]);
        end
        checks++;
        if (bcd_o[1] !== 8'h99 || tc_o[1] !== 1'b1 || run_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL halt_at_99 bcd=%h tc=%b run=%b exp 99/1/0", bcd_o[1], tc_o[1], run_o[1]);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (tc_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL tc_one_cycle inst%0d tc=%b exp 0", k, tc_o[k]);
            end
        end
        send(2'b11, 8'h01);
        tick();
        send(2'b10, '0);
        ticks(4);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bcd_o[k] !== 8'h00 || up_o[k] !== 1'b0) begin
                failures++;
                $display("FAIL down_to_00 inst%0d bcd=%h up=%b exp 00/0", k, bcd_o[k], up_o[k]);
            end
        end
        ticks(4);
        checks++;
        if (bcd_o[1] !== 8'h00 || tc_o[1] !== 1'b1 || run_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL halt_at_00 bcd=%h tc=%b run=%b exp 00/1/0", bcd_o[1], tc_o[1], run_o[1]);
        end
        checks++;
        if (bcd_o[0] !== 8'h99 || tc_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_to_99 bcd=%h tc=%b exp 99/1", bcd_o[0], tc_o[0]);
        end
        send(2'b10, '0);
        checks++;
        if (run_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL halt_rerun run=%b exp 1", run_o[1]);
        end
        ticks(4);
        checks++;
        if (bcd_o[1] !== 8'h00 || tc_o[1] !== 1'b1 || run_o[1] !== 1'b0) begin
            failures++;
            $display("FAIL rehalt bcd=%h tc=%b run=%b exp 00/1/0", bcd_o[1], tc_o[1], run_o[1]);
        end
    endtask
`else
    task automatic test_auto_reverse();
        do_reset();
        send(2'b11, 8'h98);
        tick();
        send(2'b01, '0);
        ticks(4);
        checks++;
        if (bcd_o[0] !== 8'h99) begin
            failures++;
            $display("FAIL ar_99 bcd=%h exp 99", bcd_o[0]);
        end
        ticks(4);
        checks++;
        if (bcd_o[0] !== 8'h99 || tc_o[0] !== 1'b1 || up_o[0] !== 1'b0 || run_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL ar_turn bcd=%h tc=%b up=%b run=%b exp 99/1/0/1", bcd_o[0], tc_o[0], up_o[0], run_o[0]);
        end
        ticks(4);
        checks++;
        if (bcd_o[0] !== 8'h98) begin
            failures++;
            $display("FAIL ar_98 bcd=%h exp 98", bcd_o[0]);
        end
    endtask
`endif

    task automatic test_bad_load();
        do_reset();
        send(2'b11, 8'h12);
        tick();
        send(2'b11, 8'h1A);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_o[k] !== 1'b1 || ready_o[k] !== 1'b1 || bcd_o[k] !== 8'h12) begin
                failures++;
                $display("FAIL bad_load inst%0d err=%b rdy=%b bcd=%h exp 1/1/12", k, err_o[k], ready_o[k], bcd_o[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (err_o[k] !== 1'b0 || bcd_o[k] !== 8'h12) begin
                failures++;
                $display("FAIL bad_load_after inst%0d err=%b bcd=%h exp 0/12", k, err_o[k], bcd_o[k]);
            end
        end
    endtask

    task automatic test_stop_hold();
        do_reset();
        send(2'b11, 8'h39);
        tick();
        send(2'b01, '0);
        ticks(2);
        send(2'b00, '0);
        checks++;
        if (run_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL stop_running run=%b exp 0", run_o[0]);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (bcd_o[0] !== 8'h39) begin
                failures++;
                $display("FAIL stop_hold cycle%0d bcd=%h exp 39", i, bcd_o[0]);
            end
        end
        send(2'b01, '0);
        ticks(3);
        checks++;
        if (bcd_o[0] !== 8'h39) begin
            failures++;
            $display("FAIL restart_early bcd=%h exp 39", bcd_o[0]);
        end
        tick();
        checks++;
        if (bcd_o[0] !== 8'h40) begin
            failures++;
            $display("FAIL carry_39_40 bcd=%h exp 40", bcd_o[0]);
        end
        send(2'b00, '0);
        send(2'b11, 8'h09);
        tick();
        send(2'b01, '0);
        ticks(4);
        checks++;
        if (bcd_o[0] !== 8'h10) begin
            failures++;
            $display("FAIL carry_09_10 bcd=%h exp 10", bcd_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 8'h50;
        tick();
        cmd_data = 8'h77;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (bcd_o[0] !== 8'h50) begin
            failures++;
            $display("FAIL load_ignored_busy bcd=%h exp 50", bcd_o[0]);
        end
        send(2'b01, '0);
        ticks(2);
        send(2'b10, '0);
        ticks(3);
        checks++;
        if (bcd_o[0] !== 8'h50 || up_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL dir_change_restart bcd=%h up=%b exp 50/0", bcd_o[0], up_o[0]);
        end
        tick();
        checks++;
        if (bcd_o[0] !== 8'h49) begin
            failures++;
            $display("FAIL borrow_50_49 bcd=%h exp 49", bcd_o[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(2'b11, 8'h37);
        tick();
        send(2'b10, '0);
        ticks(5);
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (bcd_o[0] !== '0 || run_o[0] !== 1'b0 || up_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_rst_run bcd=%h run=%b up=%b exp 00/0/1", bcd_o[0], run_o[0], up_o[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(2'b11, 8'h55);
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if (bcd_o[0] !== '0 || ready_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_rst_load bcd=%h rdy=%b exp 00/1", bcd_o[0], ready_o[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ticks(2);
        checks++;
        if (bcd_o[0] !== '0) begin
            failures++;
            $display("FAIL no_partial_load bcd=%h exp 00", bcd_o[0]);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 2'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6)       cmd_data = int2bcd($urandom_range(0, MAXV));
            else if (r == 6) cmd_data = int2bcd($urandom_range(MAXV - 1, MAXV));
            else if (r == 7) cmd_data = int2bcd($urandom_range(0, 1));
            else             cmd_data = BW'($urandom);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (bcd_o[k] !== int2bcd(m_val[k])) begin
                    failures++;
                    $display("FAIL rnd_bcd c%0d inst%0d got=%h exp=%h", c, k, bcd_o[k], int2bcd(m_val[k]));
                end
                checks++;
                if (up_o[k] !== m_up[k]) begin
                    failures++;
                    $display("FAIL rnd_up c%0d inst%0d got=%b exp=%b", c, k, up_o[k], m_up[k]);
                end
                checks++;
                if (run_o[k] !== (m_mode[k] == M_RUN)) begin
                    failures++;
                    $display("FAIL rnd_running c%0d inst%0d got=%b exp=%b", c, k, run_o[k], m_mode[k] == M_RUN);
                end
                checks++;
                if (ready_o[k] !== (m_mode[k] != M_LOAD)) begin
                    failures++;
                    $display("FAIL rnd_ready c%0d inst%0d got=%b exp=%b", c, k, ready_o[k], m_mode[k] != M_LOAD);
                end
                checks++;
                if (tc_o[k] !== m_tc[k]) begin
                    failures++;
                    $display("FAIL rnd_tc c%0d inst%0d got=%b exp=%b", c, k, tc_o[k], m_tc[k]);
                end
                checks++;
                if (err_o[k] !== m_err[k]) begin
                    failures++;
                    $display("FAIL rnd_err c%0d inst%0d got=%b exp=%b", c, k, err_o[k], m_err[k]);
                end
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        model_reset();
        test_reset();
        test_count_up();
`ifndef BCD_AUTO_REVERSE_EN
        test_wrap_halt();
`else
        test_auto_reverse();
`endif
        test_bad_load();
        test_stop_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
